// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions (state encoding, frame constants)
//                used by both the receiver and the transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   // Number of data bits carried by one frame
   localparam int DATA_BITS = 8;

   // Default number of tck pulses per bit period
   localparam int OVERSAMPLE_DEF = 16;

   // Frame-level state encoding shared by RX and TX
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo.sv
// ============================================================================
//  Module      : fifo
//  Description : Synchronous FIFO with occupancy count. A write to a full
//                FIFO is accepted only when a read happens in the same clk.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo #(
   parameter int DATA_SIZE   = 8,
   parameter int BUFFER_SIZE = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_wr_en,
   input  logic [DATA_SIZE-1:0]             i_wr_data,
   input  logic                             i_rd_en,
   output logic [DATA_SIZE-1:0]             o_rd_data,
   output logic                             o_full,
   output logic                             o_empty,
   output logic [$clog2(BUFFER_SIZE):0]     o_count
);

   localparam int AW = $clog2(BUFFER_SIZE);
   localparam logic [AW:0] c_full_lvl = (AW+1)'(BUFFER_SIZE);

   logic [DATA_SIZE-1:0] r_mem [BUFFER_SIZE];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_count;
   logic                 w_pop;
   logic                 w_push;

   assign o_full    = (r_count == c_full_lvl);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   // Full FIFO still takes a write when a read frees the slot in the same clk
   assign w_pop  = i_rd_en && !o_empty;
   assign w_push = i_wr_en && (!o_full || w_pop);

   // Storage array: written only, no reset needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers wrap naturally because BUFFER_SIZE is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver (8 data bits, LSB first, 1 stop)
//                with receive FIFO, flow control and error reporting.
//                Optional even parity bit enabled by macro UART_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tck,
   input  logic                 rx,
   output logic                 rts_n,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_data_valid,
   input  logic                 rx_data_ready,
   output logic                 rxfifo_full,
   output logic                 rxfifo_empty,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 rx_irq
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] c_half_bit = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] c_full_bit = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] c_last_bit = BW'(DATA_BITS - 1);
   localparam logic [AW:0]   c_rts_lvl  = (AW+1)'(FIFO_DEPTH - 1);

   uart_state_e          r_state;
   logic                 r_sync1;
   logic                 r_sync2;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_push;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 r_sticky;
   logic                 w_rx;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic [AW:0]          w_count;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bad;
   logic                 r_parity_err;
`endif

   assign w_rx = r_sync2;

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   // Frame FSM: counters move only on tck; decision pulses are one clk wide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         if (tck) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_rx) begin
                     r_state <= ST_START;
                     r_cnt   <= '0;
                  end
               end
               ST_START: begin
                  if (r_cnt == c_half_bit) begin
                     r_cnt   <= '0;
                     r_bit   <= '0;
                     // Line back high at mid-start: glitch, not a frame
                     r_state <= w_rx ? ST_IDLE : ST_DATA;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  if (r_cnt == c_full_bit) begin
                     r_cnt   <= '0;
                     r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                     r_bit   <= r_bit + 1'b1;
                     if (r_bit == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_STOP;
`endif
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               ST_PARITY: begin
                  if (r_cnt == c_full_bit) begin
                     r_cnt     <= '0;
                     r_par_bad <= (^r_shift) ^ w_rx;
                     r_state   <= ST_STOP;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
`endif
               ST_STOP: begin
                  if (r_cnt == c_full_bit) begin
                     // Leave at mid-stop so the next start edge is not missed
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                     if (!w_rx) begin
                        r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     end else if (r_par_bad) begin
                        r_parity_err <= 1'b1;
`endif
                     end else begin
                        r_push <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign w_pop = !w_empty && rx_data_ready;

   // Overrun is judged at the actual push clk so a same-clk pop still makes room
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
         r_sticky  <= 1'b0;
      end else begin
         r_overrun <= r_push && w_full && !w_pop;
         r_sticky  <= r_sticky | r_frame_err | r_overrun | parity_err;
      end
   end

   fifo #(
      .DATA_SIZE   (DATA_BITS),
      .BUFFER_SIZE (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (r_push),
      .i_wr_data (r_shift),
      .i_rd_en   (rx_data_ready),
      .o_rd_data (rx_data),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   assign rx_data_valid = !w_empty;
   assign rxfifo_full   = w_full;
   assign rxfifo_empty  = w_empty;
   assign frame_err     = r_frame_err;
   assign overrun_err   = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign parity_err    = r_parity_err;
`else
   assign parity_err    = 1'b0;
`endif
   // Not ready while in reset, otherwise throttle one slot before full
   assign rts_n         = !rst_n || (w_count >= c_rts_lvl);
   assign rx_irq        = !w_empty || r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx (OVERSAMPLE 16, tck every
//                4 clk, FIFO depth 8). Honours UART_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int BIT_CLKS = 64;   // 16 ticks x 4 clk

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tck = 1'b0;
   logic       rx = 1'b1;
   logic       rts_n;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_data_ready = 1'b0;
   logic       rxfifo_full;
   logic       rxfifo_empty;
   logic       parity_err;
   logic       frame_err;
   logic       overrun_err;
   logic       rx_irq;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int pe_cnt = 0;
   int oe_cnt = 0;
   int rise_cyc = -1;
   int start_cyc = 0;
   logic prev_valid = 1'b0;

   uart_rx #(
      .FIFO_DEPTH (8),
      .OVERSAMPLE (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tck           (tck),
      .rx            (rx),
      .rts_n         (rts_n),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready),
      .rxfifo_full   (rxfifo_full),
      .rxfifo_empty  (rxfifo_empty),
      .parity_err    (parity_err),
      .frame_err     (frame_err),
      .overrun_err   (overrun_err),
      .rx_irq        (rx_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // tck is high for posedges whose number is a multiple of 4
   always @(negedge clk) tck = (((cyc + 1) % 4) == 0);

   // Monitor: count error-pulse cycles and record valid rising edges
   always @(negedge clk) begin
      if (frame_err)   fe_cnt = fe_cnt + 1;
      if (parity_err)  pe_cnt = pe_cnt + 1;
      if (overrun_err) oe_cnt = oe_cnt + 1;
      if (rx_data_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_data_valid;
   end

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr_counts();
      fe_cnt = 0;
      pe_cnt = 0;
      oe_cnt = 0;
      rise_cyc = -1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   // Full frame plus one idle bit; records the cycle the start bit began
   task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (PAR_EN) send_bit(par_ok ? (^d) : ~(^d));
      send_bit(stop);
      send_bit(1'b1);
   endtask

   // Expected cycle of the valid rise from the start-bit cycle
   function automatic int exp_rise(input int c);
      int det;
      det = c + 3;
      while ((det % 4) != 0) det = det + 1;
      return det + 4 * (8 + 16 * (9 + int'(PAR_EN))) + 1;
   endfunction

   task automatic pop();
      rx_data_ready = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clr_counts();
   endtask

   typedef struct {
      logic [7:0] data;
      bit         par_ok;
      bit         stop;
      bit         exp_push;
      int         exp_fe;
      int         exp_pe;
   } vec_t;

   vec_t vecs [6];
   int   exp_c;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1,          0, 0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, !PAR_EN,       0, int'(PAR_EN)};
      vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0,          1, 0};
      vecs[3] = '{8'h55, 1'b1, 1'b1, 1'b1,          0, 0};
      vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1,          0, 0};
      vecs[5] = '{8'hFF, 1'b0, 1'b1, !PAR_EN,       0, int'(PAR_EN)};

      // Reset values while rst_n is held low
      repeat (3) @(negedge clk);
      check("rst valid", int'(rx_data_valid), 0);
      check("rst empty", int'(rxfifo_empty), 1);
      check("rst full",  int'(rxfifo_full), 0);
      check("rst rts_n", int'(rts_n), 1);
      check("rst errs",  int'({frame_err, parity_err, overrun_err}), 0);
      check("rst irq",   int'(rx_irq), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      clr_counts();
      check("idle rts_n", int'(rts_n), 0);

      // Table-driven single frames
      for (int v = 0; v < 6; v++) begin
         clr_counts();
         send_frame(vecs[v].data, vecs[v].par_ok, vecs[v].stop);
         repeat (4) @(negedge clk);
         check($sformatf("v%0d frame_err", v), fe_cnt, vecs[v].exp_fe);
         check($sformatf("v%0d parity_err", v), pe_cnt, vecs[v].exp_pe);
         check($sformatf("v%0d overrun", v), oe_cnt, 0);
         check($sformatf("v%0d valid", v), int'(rx_data_valid), int'(vecs[v].exp_push));
         if (vecs[v].exp_push) begin
            check($sformatf("v%0d data", v), int'(rx_data), int'(vecs[v].data));
            check($sformatf("v%0d latency", v), rise_cyc, exp_rise(start_cyc));
            pop();
         end
         check($sformatf("v%0d empty", v), int'(rxfifo_empty), 1);
      end
      check("sticky irq", int'(rx_irq), 1);

      // False start: 4-tick low glitch, then a good frame
      do_reset();
      check("irq after reset", int'(rx_irq), 0);
      rx = 1'b0;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT_CLKS) @(negedge clk);
      check("glitch valid", int'(rx_data_valid), 0);
      check("glitch errs", fe_cnt + pe_cnt + oe_cnt, 0);
      send_frame(8'h5A, 1'b1, 1'b1);
      check("post-glitch data", int'(rx_data), 8'h5A);
      pop();

      // Fill past depth with consumer stalled
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         send_frame(8'(i), 1'b1, 1'b1);
         repeat (4) @(negedge clk);
         if (i == 6) check("rts_n at 6", int'(rts_n), 0);
         if (i == 7) check("rts_n at 7", int'(rts_n), 1);
         if (i == 7) check("full at 7", int'(rxfifo_full), 0);
         if (i == 8) check("full at 8", int'(rxfifo_full), 1);
         if (i == 8) check("overrun at 8", oe_cnt, 0);
      end
      check("overrun at 9", oe_cnt, 1);
      check("full after 9", int'(rxfifo_full), 1);
      check("irq after overrun", int'(rx_irq), 1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("readback %0d", i), int'(rx_data), i);
         pop();
      end
      check("drained empty", int'(rxfifo_empty), 1);
      check("drained rts_n", int'(rts_n), 0);

      // Reset during data bit 4 of 0xC3, then a clean frame
      do_reset();
      exp_c = 8'hC3;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(exp_c[i]);
      rx = exp_c[4];
      repeat (BIT_CLKS / 2) @(negedge clk);
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset rts_n", int'(rts_n), 1);
      check("midreset empty", int'(rxfifo_empty), 1);
      rst_n = 1'b1;
      repeat (10 * BIT_CLKS) @(negedge clk);
      check("midreset no push", int'(rx_data_valid), 0);
      check("midreset no err", fe_cnt + pe_cnt + oe_cnt, 0);
      send_frame(8'h96, 1'b1, 1'b1);
      check("after reset data", int'(rx_data), 8'h96);
      pop();
      check("after reset empty", int'(rxfifo_empty), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the bench always ends on its own
   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, receive FIFO depth in bytes (power of two, >= 2).
REQ-002 Parameter OVERSAMPLE, default 16, tck pulses per bit period (even, >= 8).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 tck  input  1  oversample enable, one-clk pulse, OVERSAMPLE per bit.
REQ-006 rx  input  1  serial line, asynchronous, idle high.
REQ-007 rts_n  output  1  flow control, low = ready to receive.
REQ-008 rx_data  output  8  FIFO head byte.
REQ-009 rx_data_valid  output  1  FIFO head valid.
REQ-010 rx_data_ready  input  1  consumer accept; a pop occurs when valid && ready.
REQ-011 rxfifo_full, rxfifo_empty  output  1 each  FIFO status.
REQ-012 parity_err, frame_err, overrun_err  output  1 each  one-clk error pulses.
REQ-013 rx_irq  output  1  interrupt level.

Function
REQ-014 Frame: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
REQ-015 rx passes through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; the sample counter and bit counter advance only on tck.
REQ-017 IDLE->START on the first tck that sees synchronized rx = 0; the sample counter clears.
REQ-018 START samples at count OVERSAMPLE/2-1; rx = 1 returns to IDLE with no error (false start); otherwise -> DATA.
REQ-019 DATA samples each bit at its mid-point (every OVERSAMPLE ticks); after the 8th bit -> PARITY.
REQ-020 PARITY samples one bit; a mismatch (XOR of data and parity bits != 0) is latched.
REQ-021 STOP samples at mid-bit, then -> IDLE on the same tck, with no wait for the full stop period.
REQ-022 STOP sample 0: frame_err pulses; the byte is discarded.
REQ-023 Latched parity mismatch with a good stop bit: parity_err pulses; the byte is discarded.
REQ-024 Good byte with FIFO not full: the byte is pushed the clk after the stop sample, giving a 1-clk push latency.
REQ-025 Good byte with FIFO full: overrun_err pulses; the byte is dropped; FIFO contents are unchanged.
REQ-026 Push and pop in the same clk: both occur; the occupancy is unchanged, including when full.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; rx_data is stable while valid && !ready.
REQ-028 rts_n = 1 when occupancy >= FIFO_DEPTH-1, otherwise 0; this is a combinational function of registered occupancy.
REQ-029 rx_irq = !rxfifo_empty || sticky error; the sticky error sets on any error pulse and clears only on reset.

Reset
REQ-030 Reset state: FSM in IDLE; counters 0; FIFO empty.
REQ-031 Outputs during reset: rx_data_valid=0, rxfifo_empty=1, rxfifo_full=0, rts_n=1, all error pulses 0, rx_irq=0.
REQ-032 Synchronizer flops reset to 1.
REQ-033 Reset asserted mid-frame aborts the frame immediately; no partial byte is ever pushed.

Configuration
REQ-034 Macro UART_RX_PARITY_EN defined: the frame is 11 bits, per REQ-014.
REQ-035 Macro UART_RX_PARITY_EN undefined: the PARITY state is removed, the frame is 10 bits (DATA->STOP), and parity_err is tied 0.

Structure
REQ-036 Package uart_pkg holds: the FSM state enum, the DATA_BITS=8 constant, and the default OVERSAMPLE constant, all shared with the transmitter.
REQ-037 Buffering instantiates the existing fifo sub-module (data_size 8, buffer_size FIFO_DEPTH); the FSM and synchronizer live in uart_rx.

Verification
REQ-038 Byte 0xA5 with parity 0 and stop 1, tck every 4 clk -> rx_data=0xA5, valid 1 clk after the stop sample, no errors.
REQ-039 Byte 0x01 with parity 0 (wrong) -> parity_err pulses 1 clk, FIFO stays empty, rx_irq=1.
REQ-040 Byte 0x3C with stop 0 -> frame_err pulses, nothing pushed; a following good 0x55 is received correctly.
REQ-041 Nine bytes sent, rx_data_ready=0, depth 8 -> rts_n=1 after byte 7, full after byte 8, overrun_err on byte 9; reading returns bytes 1..8 in order.
REQ-042 rx low pulse of 4 ticks -> false start, return to IDLE, no push, no error.
REQ-043 rst_n asserted during DATA bit 4 -> state IDLE, FIFO empty; the next full frame is received intact.
